// File: rtl/pps_meas_pkg.sv
// Shared types and helpers for the 1PPS phase meter: FSM state, sign convention, negate helper.
package pps_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LEAD_GPS = 2'd1,
    ST_LEAD_LOC = 2'd2
  } pps_state_t;

  // +1: a positive result means the local 1PPS lags GPS (GPS edge came first).
  localparam int PHASE_LOCAL_LAGS = 1;

  // Two's-complement negate of an unsigned magnitude in a w-bit field.
  // Magnitudes beyond 2**(w-1) clamp to the most negative code.
  function automatic logic [63:0] sat_neg(input logic [63:0] cnt, input int w);
    logic [63:0] lim;
    logic [63:0] mag;
    lim = 64'd1 << (w - 1);
    mag = (cnt > lim) ? lim : cnt;
    return (~mag + 64'd1) & ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/pps_phase_meter_if.sv
// Signal bundle between the phase meter and its pulse sources / loop-filter consumer.
interface pps_phase_meter_if #(
  parameter int W = 24
);
  import pps_meas_pkg::*;

  // No valid/ready here: Phase_Valid, Phase_Timeout and Avg_Valid are single-cycle
  // strobes with no backpressure; the consumer must capture the data on the strobe
  // cycle. Phase_Out and Phase_Avg hold between strobes.
  logic         PPS_GPS;
  logic         PPS_Local;
  logic [W-1:0] Phase_Out;
  logic         Phase_Valid;
  logic         Phase_Timeout;
  logic         GPS_Edge;
  logic         Local_Edge;
  logic [W-1:0] Phase_Avg;
  logic         Avg_Valid;
  pps_state_t   Dbg_State;

  modport master (
    output PPS_GPS, PPS_Local,
    input  Phase_Out, Phase_Valid, Phase_Timeout, GPS_Edge, Local_Edge,
           Phase_Avg, Avg_Valid, Dbg_State
  );

  modport slave (
    input  PPS_GPS, PPS_Local,
    output Phase_Out, Phase_Valid, Phase_Timeout, GPS_Edge, Local_Edge,
           Phase_Avg, Avg_Valid, Dbg_State
  );

endinterface

// File: rtl/pps_edge_sync.sv
// Three-flop synchroniser with rising-edge pulse; flops reset high so a level
// already high at reset release never produces an edge.
module pps_edge_sync (
  input  logic CLK_SYS,
  input  logic CLK_RST,
  input  logic i_async,
  output logic o_edge
);

  logic [2:0] r_sync;

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      r_sync <= 3'b111;
    end else begin
      r_sync <= {r_sync[1:0], i_async};
    end
  end

  assign o_edge = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/pps_phase_meter.sv
// Signed phase meter between GPS and local 1PPS, in CLK_SYS cycles (positive: local lags).
// Optional 2**AVG_LOG2 sample averager is built when PPS_PHASE_AVG_EN is defined.
module pps_phase_meter
  import pps_meas_pkg::*;
#(
  parameter int W           = 24,
  parameter int TIMEOUT_CYC = 10_000_000,
  parameter int AVG_LOG2    = 2
) (
  input  logic             CLK_SYS,
  input  logic             CLK_RST,
  pps_phase_meter_if.slave bus
);

  localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT_CYC);

  logic         w_gps_edge;
  logic         w_loc_edge;
  pps_state_t   r_state,   w_state_nxt;
  logic [W-1:0] r_cnt,     w_cnt_nxt;
  logic [W-1:0] r_phase,   w_phase_nxt;
  logic         r_valid,   w_valid_nxt;
  logic         r_timeout, w_timeout_nxt;
  logic [W-1:0] w_neg;
  logic [W-1:0] w_gps_lead_phase;
  logic [W-1:0] w_loc_lead_phase;

  pps_edge_sync u_sync_gps (
    .CLK_SYS (CLK_SYS),
    .CLK_RST (CLK_RST),
    .i_async (bus.PPS_GPS),
    .o_edge  (w_gps_edge)
  );

  pps_edge_sync u_sync_loc (
    .CLK_SYS (CLK_SYS),
    .CLK_RST (CLK_RST),
    .i_async (bus.PPS_Local),
    .o_edge  (w_loc_edge)
  );

  assign w_neg            = W'(sat_neg(64'(r_cnt), W));
  assign w_gps_lead_phase = (PHASE_LOCAL_LAGS > 0) ? r_cnt : w_neg;
  assign w_loc_lead_phase = (PHASE_LOCAL_LAGS > 0) ? w_neg : r_cnt;

  // A closing edge wins over a repeated leading edge in the same cycle; a repeat
  // restarts the count (newest leading edge is the reference).
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_phase_nxt   = r_phase;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gps_edge && w_loc_edge) begin
          w_phase_nxt = '0;
          w_valid_nxt = 1'b1;
        end else if (w_gps_edge) begin
          w_cnt_nxt   = W'(1);
          w_state_nxt = ST_LEAD_GPS;
        end else if (w_loc_edge) begin
          w_cnt_nxt   = W'(1);
          w_state_nxt = ST_LEAD_LOC;
        end
      end
      ST_LEAD_GPS: begin
        if (w_loc_edge) begin
          w_phase_nxt = w_gps_lead_phase;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_gps_edge) begin
          w_cnt_nxt = W'(1);
        end else if (r_cnt == TIMEOUT_W) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + W'(1);
        end
      end
      ST_LEAD_LOC: begin
        if (w_gps_edge) begin
          w_phase_nxt = w_loc_lead_phase;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_loc_edge) begin
          w_cnt_nxt = W'(1);
        end else if (r_cnt == TIMEOUT_W) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_phase   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_phase   <= w_phase_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign bus.Phase_Out     = r_phase;
  assign bus.Phase_Valid   = r_valid;
  assign bus.Phase_Timeout = r_timeout;
  assign bus.GPS_Edge      = w_gps_edge;
  assign bus.Local_Edge    = w_loc_edge;
  assign bus.Dbg_State     = r_state;

`ifdef PPS_PHASE_AVG_EN
  localparam int              AW     = W + AVG_LOG2;
  localparam int              NW     = AVG_LOG2 + 1;
  localparam logic [NW-1:0]   N_LAST = NW'((1 << AVG_LOG2) - 1);

  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] w_acc_sum;
  logic [NW-1:0]        r_n;
  logic [W-1:0]         r_avg;
  logic                 r_avg_valid;

  assign w_acc_sum = r_acc + AW'($signed(r_phase));

  // Samples are taken from the registered result on its strobe cycle; the
  // arithmetic shift rounds the mean toward minus infinity.
  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      r_acc       <= '0;
      r_n         <= '0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= 1'b0;
      if (r_timeout) begin
        r_acc <= '0;
        r_n   <= '0;
      end else if (r_valid) begin
        if (r_n == N_LAST) begin
          r_avg       <= W'(w_acc_sum >>> AVG_LOG2);
          r_avg_valid <= 1'b1;
          r_acc       <= '0;
          r_n         <= '0;
        end else begin
          r_acc <= w_acc_sum;
          r_n   <= r_n + NW'(1);
        end
      end
    end
  end

  assign bus.Phase_Avg = r_avg;
  assign bus.Avg_Valid = r_avg_valid;
`else
  assign bus.Phase_Avg = '0;
  assign bus.Avg_Valid = 1'b0;
`endif

endmodule

// File: tb/tb_pps_phase_meter.sv
// Self-checking bench for pps_phase_meter: directed and randomized edge pairs,
// repeats, timeouts and reset, against an edge-time reference model.
module tb_pps_phase_meter;
  import pps_meas_pkg::*;

  localparam int W  = 24;
  localparam int T  = 1000;
  localparam int AL = 2;

  typedef struct {
    int           nv;
    int           nt;
    int           v_at;
    int           t_at;
    int           ng;
    int           nl;
    int           na;
    int           nboth;
    logic [W-1:0] ph;
    logic [W-1:0] av;
  } res_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pps_phase_meter_if #(.W(W)) bus ();

  pps_phase_meter #(
    .W           (W),
    .TIMEOUT_CYC (T),
    .AVG_LOG2    (AL)
  ) dut (
    .CLK_SYS (clk),
    .CLK_RST (rst_n),
    .bus     (bus)
  );

  // ---------------- scoreboard ----------------
  int           n_vec = 0;
  int           n_err = 0;
  int           l_ref = -1;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_phase = '0;
  int           avg_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%06h expected 0x%06h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_phase"},   bus.Phase_Out,            '0);
    check({pfx, "_valid"},   W'(bus.Phase_Valid),      '0);
    check({pfx, "_timeout"}, W'(bus.Phase_Timeout),    '0);
    check({pfx, "_gedge"},   W'(bus.GPS_Edge),         '0);
    check({pfx, "_ledge"},   W'(bus.Local_Edge),       '0);
    check({pfx, "_avg"},     bus.Phase_Avg,            '0);
    check({pfx, "_avgv"},    W'(bus.Avg_Valid),        '0);
    check({pfx, "_state"},   W'(bus.Dbg_State),        W'(ST_IDLE));
  endtask

  // ---------------- driver ----------------
  // Each pulse is one clock high, driven at the negedge of cycle index c.
  task automatic apply(input int tg, input int tg2, input int tl, input int tl2,
                       input int budget, output res_t r);
    r = '{nv: 0, nt: 0, v_at: -1, t_at: -1, ng: 0, nl: 0, na: 0, nboth: 0, ph: '0, av: '0};
    for (int c = 0; c < budget; c++) begin
      bus.PPS_GPS   = (c == tg) || (c == tg2);
      bus.PPS_Local = (c == tl) || (c == tl2);
      @(negedge clk);
      if (bus.GPS_Edge)   r.ng++;
      if (bus.Local_Edge) r.nl++;
      if (bus.Phase_Valid) begin
        r.nv++;
        if (r.v_at < 0) begin
          r.v_at = c + 1;
          r.ph   = bus.Phase_Out;
        end
      end
      if (bus.Phase_Timeout) begin
        r.nt++;
        if (r.t_at < 0) r.t_at = c + 1;
      end
      if (bus.Phase_Valid && bus.Phase_Timeout) r.nboth++;
      if (bus.Avg_Valid) begin
        r.na++;
        r.av = bus.Phase_Avg;
      end
    end
    bus.PPS_GPS   = 1'b0;
    bus.PPS_Local = 1'b0;
  endtask

  function automatic int floor_div(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_avg_sample(input int sd, input res_t r);
`ifdef PPS_PHASE_AVG_EN
    int s;
    avg_q.push_back(sd);
    if (avg_q.size() == (1 << AL)) begin
      s = 0;
      foreach (avg_q[i]) s += avg_q[i];
      check("avg_strobes", W'(r.na), W'(1));
      check("avg_value", r.av, W'(floor_div(s, 1 << AL)));
      avg_q.delete();
    end else begin
      check("avg_strobes", W'(r.na), W'(0));
    end
`else
    avg_q.push_back(sd);
    check("avg_strobes", W'(r.na), W'(0));
    check("avg_tied", bus.Phase_Avg, '0);
`endif
  endtask

  // Leader pulses at cycle 2 (and optionally again rep cycles later); the
  // other input closes d cycles after the last leader pulse.
  task automatic do_pair(input bit gps_lead, input int d, input int rep);
    int           lead0;
    int           lead_last;
    int           close_t;
    int           sd;
    logic [W-1:0] e;
    res_t         r;
    lead0     = 2;
    lead_last = (rep > 0) ? lead0 + rep : lead0;
    close_t   = lead_last + d;
    if (gps_lead)
      apply(lead0, (rep > 0) ? lead_last : -1, close_t, -1, close_t + 8, r);
    else
      apply(close_t, -1, lead0, (rep > 0) ? lead_last : -1, close_t + 8, r);
    sd = (d == 0) ? 0 : (gps_lead ? d : -d);
    e  = W'(sd);
    exp_q.push_back(e);
    check("valid_strobes", W'(r.nv), W'(1));
    check("timeout_strobes", W'(r.nt), W'(0));
    check("both_strobes", W'(r.nboth), W'(0));
    if (l_ref < 0) begin
      l_ref = r.v_at - close_t;
      check("latency_range", W'((l_ref >= 2) && (l_ref <= 4)), W'(1));
    end else begin
      check("latency", W'(r.v_at - close_t), W'(l_ref));
    end
    check("phase", r.ph, exp_q.pop_front());
    check("gps_edges", W'(r.ng), W'((gps_lead && rep > 0) ? 2 : 1));
    check("loc_edges", W'(r.nl), W'((!gps_lead && rep > 0) ? 2 : 1));
    check("phase_hold", bus.Phase_Out, e);
    check("state_idle", W'(bus.Dbg_State), W'(ST_IDLE));
    last_phase = e;
    model_avg_sample(sd, r);
  endtask

  task automatic do_timeout(input bit gps_lead);
    res_t r;
    apply(gps_lead ? 2 : -1, -1, gps_lead ? -1 : 2, -1, 2 + T + 10, r);
    check("to_strobes", W'(r.nt), W'(1));
    check("to_valid_strobes", W'(r.nv), W'(0));
    check("to_time", W'(r.t_at - 2), W'(T + l_ref));
    check("to_phase_hold", bus.Phase_Out, last_phase);
    check("to_state_idle", W'(bus.Dbg_State), W'(ST_IDLE));
    check("to_avg_strobes", W'(r.na), W'(0));
    avg_q.delete();
  endtask

  task automatic do_reset_mid_meas();
    res_t r;
    int   n_edges;
    int   n_strobes;
    apply(2, -1, -1, -1, 2 + 500, r);
    check("pre_rst_strobes", W'(r.nv + r.nt), W'(0));
    check("pre_rst_state", W'(bus.Dbg_State), W'(ST_LEAD_GPS));
    bus.PPS_GPS   = 1'b1;
    bus.PPS_Local = 1'b1;
    rst_n         = 1'b0;
    #1;
    check_zero("midrst");
    repeat (5) @(negedge clk);
    check_zero("midrst_hold");
    rst_n = 1'b1;
    last_phase = '0;
    avg_q.delete();
    n_edges   = 0;
    n_strobes = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.GPS_Edge || bus.Local_Edge) n_edges++;
      if (bus.Phase_Valid || bus.Phase_Timeout || bus.Avg_Valid) n_strobes++;
    end
    check("held_high_edges", W'(n_edges), W'(0));
    check("held_high_strobes", W'(n_strobes), W'(0));
    bus.PPS_GPS   = 1'b0;
    bus.PPS_Local = 1'b0;
    repeat (4) @(negedge clk);
    do_pair(1'b1, 30, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d;
    int rep;
    bit gl;
    bus.PPS_GPS   = 1'b0;
    bus.PPS_Local = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    do_pair(1'b1, 100, 0);
    do_pair(1'b0, 250, 0);
    do_pair(1'b1, 0, 0);
    do_timeout(1'b1);
    do_pair(1'b1, 40, 0);

    do_timeout(1'b0);
    do_pair(1'b1, 10, 0);
    do_pair(1'b1, 12, 0);
    do_pair(1'b1, 14, 0);
    do_pair(1'b0, 4, 0);

    do_pair(1'b1, T, 0);
    do_pair(1'b0, T, 0);
    do_timeout(1'b1);
    do_pair(1'b1, 50, 20);
    do_pair(1'b0, 7, 300);
    do_pair(1'b0, 1, 0);

    for (int i = 0; i < 14; i++) begin
      gl  = 1'($urandom_range(0, 1));
      d   = int'($urandom_range(0, T));
      rep = (d > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(2, 200)) : 0;
      do_pair(gl, d, rep);
    end

    do_reset_mid_meas();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
